register_file_param: RTL and testbench
======================================

# register_file_param

Parametrised two-read / two-write register file, the next generation of the single-write register file used in the datapath. It adds configurable data width and depth, a second write port with fixed priority, an optional hardwired zero register, optional write-to-read bypass, and a hardware clear sweep with a `busy` flag. Read data is registered, giving one cycle of latency. The block sits between instruction decode (register addresses) and the execute stage (operands), with writeback driving both write ports.

## Interface
- `DATA_WIDTH`, default 64: width of each register.
- `ADDR_WIDTH`, default 5: address width; `DEPTH` = 2^`ADDR_WIDTH` registers.
- `ZERO_REG`, default 1: if 1, register 0 reads as 0 and ignores writes.
- `BYPASS`, default 1: if 1, same-cycle write data is forwarded to a matching read.

Ports (name, direction, width, meaning):
- `Clk` in 1: the single clock; all state changes on its rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `En` in 1: global enable. When 0, writes are ignored and `read_data*` hold their value. The clear sweep is not gated by `En`.
- `clear_req` in 1: request a full clear sweep. Sampled only in IDLE with `En`=1.
- `busy` out 1: high while a clear sweep is in progress.
- `read_reg1`, `read_reg2` in `ADDR_WIDTH`: read addresses.
- `read_data1`, `read_data2` out `DATA_WIDTH`: registered read data.
- `write_reg1`, `write_reg2` in `ADDR_WIDTH`: write addresses.
- `write_data1`, `write_data2` in `DATA_WIDTH`: write data.
- `reg_write1`, `reg_write2` in 1: write strobes.

## Operation
FSM states:
- CLEAR: sweep pointer `ptr` (`ADDR_WIDTH` bits) zeroes one register per cycle.
- IDLE: normal read/write operation.

Reset:
- `Rst` high at an edge sets state to CLEAR, `ptr` to 0, `busy` to 1, and both `read_data*` to 0.
- The reset edge itself does not write memory.
- `Rst` asserted mid-sweep restarts the sweep from `ptr`=0.

CLEAR behaviour:
- Each edge with `Rst`=0: `mem[ptr]` is set to 0.
- If `ptr`==`DEPTH`-1, state goes to IDLE and `busy` to 0. Otherwise `ptr` increments.
- Write strobes are ignored and `read_data*` are driven to 0.

IDLE writes, on an edge with `En`=1:
- Write port k with `reg_write`k=1 commits `write_data`k to `mem[write_reg`k`]`.
- If both ports target the same address, port 2 wins.
- If `ZERO_REG`=1, writes to address 0 are discarded.

IDLE reads, on an edge with `En`=1:
- `read_data`n is loaded with `mem[read_reg`n`]` as it was before the edge.
- With `BYPASS`=1, if a committing write matches `read_reg`n, that write's data is loaded instead (port 2 has priority when both match).
- With `BYPASS`=0, the old contents are loaded.
- With `ZERO_REG`=1, address 0 always loads 0, regardless of bypass.

Clear request:
- `clear_req`=1 in IDLE with `En`=1: state goes to CLEAR, `ptr` to 0, `busy` to 1.
- Writes presented in that cycle are discarded. Reads in that cycle complete normally.
- `clear_req` is ignored while in CLEAR.

## Timing
- Read latency: 1 cycle. The address is sampled at edge k and the data is valid after edge k.
- Write latency: the write commits at the edge. A read of the same address in the following cycle sees it, whether or not bypass is enabled.
- Clear duration: exactly `DEPTH` edges after `Rst` falls, or after the `clear_req` edge. `busy` falls on the `DEPTH`-th edge. The first write is accepted on the next edge.
- Reset values: `busy`=1, `read_data1`=`read_data2`=0, state CLEAR.
- `ptr` wraps only through the terminal check. It never exceeds `DEPTH`-1.

## Test plan
Default parameters unless noted.
1. Reset sweep: pulse `Rst` for 1 cycle.
   - `busy` stays high for exactly 32 edges, then falls.
   - Reads of regs 0 to 31 all return 0.
   - A write of 59 to reg 1 attempted during `busy` is lost (reg 1 reads 0).
2. Basic write/read: write 59 to reg 1, then 128 to reg 2.
   - `read_reg1`=2, `read_reg2`=1 gives `read_data1`=128 and `read_data2`=59, one cycle after the reads are presented.
3. Dual-write conflict: same edge, port 1 writes 0xAAAA and port 2 writes 0x5555, both to reg 7.
   - Next read of reg 7 returns 0x5555.
   - Reg 0 written with 0xFFFF reads 0 (`ZERO_REG`=1).
4. Bypass:
   - `BYPASS`=1: write 0x1234 to reg 3 while reading reg 3 in the same cycle; `read_data1`=0x1234 after that edge.
   - `BYPASS`=0: same stimulus gives the prior value (0); the following cycle gives 0x1234.
5. Enable hold: with `En`=0, assert `reg_write1` writing 99 to reg 4 and change `read_reg1`.
   - `read_data1` holds its value and reg 4 is unchanged.
6. Clear / reset interaction:
   - `clear_req` in IDLE with a concurrent write to reg 5: the write is discarded, `busy` rises, and all registers are 0 after 32 edges.
   - `Rst` asserted at sweep cycle 10: the sweep restarts, and `busy` falls 32 edges after `Rst` drops.

Source files
------------

// File: rtl/register_file_param.sv
// register_file_param: two-read / two-write register file with registered
// reads, port-2 write priority, optional hardwired zero register, optional
// write-to-read forwarding and a one-register-per-cycle clear sweep.
module register_file_param #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  En,
   input  logic                  clear_req,
   output logic                  busy,
   input  logic [ADDR_WIDTH-1:0] read_reg1,
   input  logic [ADDR_WIDTH-1:0] read_reg2,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2,
   input  logic [ADDR_WIDTH-1:0] write_reg1,
   input  logic [ADDR_WIDTH-1:0] write_reg2,
   input  logic [DATA_WIDTH-1:0] write_data1,
   input  logic [DATA_WIDTH-1:0] write_data2,
   input  logic                  reg_write1,
   input  logic                  reg_write2
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_IDLE  = 1'b1;

   localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [0:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q,   ptr_d;
   logic                  busy_q,  busy_d;
   logic [DATA_WIDTH-1:0] rd1_q,   rd1_d;
   logic [DATA_WIDTH-1:0] rd2_q,   rd2_d;
   logic                  we1_s,   we2_s;

   // Operand selection for one read port: stored value, overridden by a
   // committing write to the same address (port 2 last so it wins), and
   // forced to zero for the hardwired register.
   function automatic logic [DATA_WIDTH-1:0] read_sel(
      input logic [ADDR_WIDTH-1:0] raddr,
      input logic [DATA_WIDTH-1:0] stored,
      input logic                  w1,
      input logic [ADDR_WIDTH-1:0] waddr1,
      input logic [DATA_WIDTH-1:0] wdata1,
      input logic                  w2,
      input logic [ADDR_WIDTH-1:0] waddr2,
      input logic [DATA_WIDTH-1:0] wdata2
   );
      logic [DATA_WIDTH-1:0] val;
      val = stored;
      if (BYPASS != 0) begin
         if (w1 && (waddr1 == raddr)) begin
            val = wdata1;
         end else begin
            val = val;
         end
         if (w2 && (waddr2 == raddr)) begin
            val = wdata2;
         end else begin
            val = val;
         end
      end else begin
         val = stored;
      end
      if ((ZERO_REG != 0) && (raddr == ADDR_ZERO)) begin
         val = DATA_ZERO;
      end else begin
         val = val;
      end
      return val;
   endfunction

   // Write qualification: only in IDLE, enabled, no clear request, and never to the zero register.
   always_comb begin
      we1_s = 1'b0;
      we2_s = 1'b0;
      if ((state_q == ST_IDLE) && En && !clear_req) begin
         we1_s = reg_write1 && !((ZERO_REG != 0) && (write_reg1 == ADDR_ZERO));
         we2_s = reg_write2 && !((ZERO_REG != 0) && (write_reg2 == ADDR_ZERO));
      end else begin
         we1_s = 1'b0;
         we2_s = 1'b0;
      end
   end

   // Next-state logic for the sweep FSM and the read-data registers.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      busy_d  = busy_q;
      rd1_d   = rd1_q;
      rd2_d   = rd2_q;
      case (state_q)
         ST_CLEAR: begin
            rd1_d = DATA_ZERO;
            rd2_d = DATA_ZERO;
            if (ptr_q == PTR_LAST) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               ptr_d   = ptr_q;
            end else begin
               ptr_d   = ptr_q + ADDR_WIDTH'(1);
            end
         end
         ST_IDLE: begin
            if (En) begin
               rd1_d = read_sel(read_reg1, mem_q[read_reg1], we1_s, write_reg1,
                                write_data1, we2_s, write_reg2, write_data2);
               rd2_d = read_sel(read_reg2, mem_q[read_reg2], we1_s, write_reg1,
                                write_data1, we2_s, write_reg2, write_data2);
               if (clear_req) begin
                  state_d = ST_CLEAR;
                  ptr_d   = ADDR_ZERO;
                  busy_d  = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               rd1_d = rd1_q;
               rd2_d = rd2_q;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            ptr_d   = ADDR_ZERO;
            busy_d  = 1'b1;
            rd1_d   = DATA_ZERO;
            rd2_d   = DATA_ZERO;
         end
      endcase
   end

   // Control and read-data registers with synchronous reset into the sweep.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_CLEAR;
         ptr_q   <= ADDR_ZERO;
         busy_q  <= 1'b1;
         rd1_q   <= DATA_ZERO;
         rd2_q   <= DATA_ZERO;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
      end
   end

   // Storage array: sweep zeroing in CLEAR, port writes in IDLE (port 2 assigned last so it wins).
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         if (state_q == ST_CLEAR) begin
            mem_q[ptr_q] <= DATA_ZERO;
         end else begin
            if (we1_s) begin
               mem_q[write_reg1] <= write_data1;
            end
            if (we2_s) begin
               mem_q[write_reg2] <= write_data2;
            end
         end
      end
   end

   assign busy       = busy_q;
   assign read_data1 = rd1_q;
   assign read_data2 = rd2_q;

endmodule

// File: tb/tb_register_file_param.sv
// Self-checking bench for register_file_param: a behavioural model predicts
// read data and busy for each edge and queues the expectation; each test
// pops and compares after the edge. A second instance runs with BYPASS=0.
module tb_register_file_param;

   typedef struct packed {
      logic        busy;
      logic [63:0] d1;
      logic [63:0] d2;
      logic [63:0] n1;
      logic [63:0] n2;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Rst, En, clear_req;
   logic [4:0]  read_reg1, read_reg2, write_reg1, write_reg2;
   logic [63:0] write_data1, write_data2;
   logic        reg_write1, reg_write2;
   logic        busy, busy_nb;
   logic [63:0] read_data1, read_data2, nb_data1, nb_data2;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   exp_t e;

   // model state
   logic        m_clear;
   int          m_ptr;
   logic        m_busy;
   logic [63:0] m_mem [32];
   logic [63:0] m_d1, m_d2, m_n1, m_n2;

   always #5 Clk = ~Clk;

   register_file_param dut (
      .Clk(Clk), .Rst(Rst), .En(En), .clear_req(clear_req), .busy(busy),
      .read_reg1(read_reg1), .read_reg2(read_reg2),
      .read_data1(read_data1), .read_data2(read_data2),
      .write_reg1(write_reg1), .write_reg2(write_reg2),
      .write_data1(write_data1), .write_data2(write_data2),
      .reg_write1(reg_write1), .reg_write2(reg_write2)
   );

   register_file_param #(.BYPASS(0)) dut_nb (
      .Clk(Clk), .Rst(Rst), .En(En), .clear_req(clear_req), .busy(busy_nb),
      .read_reg1(read_reg1), .read_reg2(read_reg2),
      .read_data1(nb_data1), .read_data2(nb_data2),
      .write_reg1(write_reg1), .write_reg2(write_reg2),
      .write_data1(write_data1), .write_data2(write_data2),
      .reg_write1(reg_write1), .reg_write2(reg_write2)
   );

   // Drive one cycle, advance the model for that edge, queue the expectation, wait past the edge.
   task automatic step(input logic rst, input logic en, input logic clr,
                       input logic rw1, input logic [4:0] wr1, input logic [63:0] wd1,
                       input logic rw2, input logic [4:0] wr2, input logic [63:0] wd2,
                       input logic [4:0] r1, input logic [4:0] r2);
      logic [63:0] o1, o2;
      logic w1, w2;
      Rst = rst; En = en; clear_req = clr;
      reg_write1 = rw1; write_reg1 = wr1; write_data1 = wd1;
      reg_write2 = rw2; write_reg2 = wr2; write_data2 = wd2;
      read_reg1 = r1; read_reg2 = r2;
      if (rst) begin
         m_clear = 1'b1; m_ptr = 0; m_busy = 1'b1;
         m_d1 = 64'd0; m_d2 = 64'd0; m_n1 = 64'd0; m_n2 = 64'd0;
      end else if (m_clear) begin
         m_mem[m_ptr] = 64'd0;
         m_d1 = 64'd0; m_d2 = 64'd0; m_n1 = 64'd0; m_n2 = 64'd0;
         if (m_ptr == 31) begin
            m_clear = 1'b0; m_busy = 1'b0;
         end else begin
            m_ptr = m_ptr + 1;
         end
      end else if (en) begin
         o1 = (r1 == 5'd0) ? 64'd0 : m_mem[r1];
         o2 = (r2 == 5'd0) ? 64'd0 : m_mem[r2];
         w1 = rw1 && !clr && (wr1 != 5'd0);
         w2 = rw2 && !clr && (wr2 != 5'd0);
         m_n1 = o1; m_n2 = o2;
         m_d1 = o1; m_d2 = o2;
         if (w1 && wr1 == r1 && r1 != 5'd0) m_d1 = wd1;
         if (w2 && wr2 == r1 && r1 != 5'd0) m_d1 = wd2;
         if (w1 && wr1 == r2 && r2 != 5'd0) m_d2 = wd1;
         if (w2 && wr2 == r2 && r2 != 5'd0) m_d2 = wd2;
         if (w1) m_mem[wr1] = wd1;
         if (w2) m_mem[wr2] = wd2;
         if (clr) begin
            m_clear = 1'b1; m_ptr = 0; m_busy = 1'b1;
         end
      end
      sb.push_back('{busy: m_busy, d1: m_d1, d2: m_d2, n1: m_n1, n2: m_n2});
      @(posedge Clk);
      #1;
   endtask

   // Idle read-only cycle helper (no comparison inside).
   task automatic rd(input logic [4:0] r1, input logic [4:0] r2);
      step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, r1, r2);
   endtask

   task automatic test_reset;
      int n;
      step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
      e = sb.pop_front();
      checks++;
      if (busy !== 1'b1 || read_data1 !== 64'd0 || read_data2 !== 64'd0) begin
         errors++;
         $display("FAIL reset_state busy=%b d1=%h d2=%h expected busy=1 d=0", busy, read_data1, read_data2);
      end
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         // attempted write of 59 to reg 1 mid-sweep must be lost
         step(1'b0, 1'b1, 1'b0, (n == 5), 5'd1, 64'd59, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2);
         n++;
         e = sb.pop_front();
         checks++;
         if (busy !== e.busy || read_data1 !== 64'd0) begin
            errors++;
            $display("FAIL sweep_cycle n=%0d busy=%b d1=%h expected busy=%b d1=0", n, busy, read_data1, e.busy);
         end
      end
      checks++;
      if (n != 32) begin
         errors++;
         $display("FAIL reset_sweep_len edges=%0d expected 32", n);
      end
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), 5'(31 - i));
         e = sb.pop_front();
         checks++;
         if (read_data1 !== 64'd0 || read_data2 !== 64'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cleared_read reg=%0d d1=%h d2=%h expected 0", i, read_data1, read_data2);
         end
      end
   endtask

   task automatic test_basic;
      step(1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 64'd59, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
      e = sb.pop_front();
      step(1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 64'd128, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
      e = sb.pop_front();
      rd(5'd2, 5'd1);
      e = sb.pop_front();
      checks++;
      if (read_data1 !== 64'd128 || read_data2 !== 64'd59) begin
         errors++;
         $display("FAIL basic_rw d1=%0d d2=%0d expected 128 59", read_data1, read_data2);
      end
   endtask

   task automatic test_dual_write;
      step(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 64'hAAAA, 1'b1, 5'd7, 64'h5555, 5'd1, 5'd2);
      e = sb.pop_front();
      step(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 64'hFFFF, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2);
      e = sb.pop_front();
      rd(5'd7, 5'd0);
      e = sb.pop_front();
      checks++;
      if (read_data1 !== 64'h5555 || read_data2 !== 64'd0) begin
         errors++;
         $display("FAIL dual_write_zero d1=%h d2=%h expected 5555 0", read_data1, read_data2);
      end
      // port 2 writing reg 0 while reading reg 0: zero wins over forwarding
      step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFFFF, 5'd0, 5'd7);
      e = sb.pop_front();
      checks++;
      if (read_data1 !== 64'd0 || read_data2 !== 64'h5555) begin
         errors++;
         $display("FAIL zero_bypass d1=%h d2=%h expected 0 5555", read_data1, read_data2);
      end
   endtask

   task automatic test_bypass;
      step(1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 64'h1234, 1'b0, 5'd0, 64'd0, 5'd3, 5'd3);
      e = sb.pop_front();
      checks++;
      if (read_data1 !== 64'h1234 || read_data2 !== 64'h1234 || nb_data1 !== 64'd0) begin
         errors++;
         $display("FAIL bypass_same_cycle d1=%h d2=%h nb1=%h expected 1234 1234 0", read_data1, read_data2, nb_data1);
      end
      rd(5'd3, 5'd7);
      e = sb.pop_front();
      checks++;
      if (read_data1 !== 64'h1234 || nb_data1 !== 64'h1234 || nb_data2 !== 64'h5555) begin
         errors++;
         $display("FAIL bypass_next_cycle d1=%h nb1=%h nb2=%h expected 1234 1234 5555", read_data1, nb_data1, nb_data2);
      end
   endtask

   task automatic test_enable_hold;
      step(1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 64'd99, 1'b0, 5'd0, 64'd0, 5'd2, 5'd1);
      e = sb.pop_front();
      checks++;
      if (read_data1 !== e.d1 || read_data1 !== 64'h1234 || read_data2 !== 64'h5555) begin
         errors++;
         $display("FAIL enable_hold d1=%h d2=%h expected 1234 5555", read_data1, read_data2);
      end
      rd(5'd4, 5'd2);
      e = sb.pop_front();
      checks++;
      if (read_data1 !== 64'd0 || read_data2 !== 64'd128) begin
         errors++;
         $display("FAIL enable_nowrite d1=%h d2=%h expected 0 80", read_data1, read_data2);
      end
   endtask

   task automatic test_clear;
      int n;
      step(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 64'hBEEF, 1'b0, 5'd0, 64'd0, 5'd3, 5'd5);
      e = sb.pop_front();
      checks++;
      if (busy !== 1'b1 || read_data1 !== 64'h1234 || read_data2 !== 64'd0) begin
         errors++;
         $display("FAIL clear_req busy=%b d1=%h d2=%h expected 1 1234 0", busy, read_data1, read_data2);
      end
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         step(1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 64'd77, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
         e = sb.pop_front();
         n++;
      end
      checks++;
      if (n != 32) begin
         errors++;
         $display("FAIL clear_sweep_len edges=%0d expected 32", n);
      end
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), 5'd5);
         e = sb.pop_front();
         checks++;
         if (read_data1 !== 64'd0 || read_data2 !== 64'd0) begin
            errors++;
            $display("FAIL clear_contents reg=%0d d1=%h d2=%h expected 0", i, read_data1, read_data2);
         end
      end
   endtask

   task automatic test_reset_mid_sweep;
      int n;
      step(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
      e = sb.pop_front();
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
         e = sb.pop_front();
      end
      step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
      e = sb.pop_front();
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
         e = sb.pop_front();
         n++;
      end
      checks++;
      if (n != 32) begin
         errors++;
         $display("FAIL reset_restart_len edges=%0d expected 32", n);
      end
   endtask

   task automatic test_back_to_back;
      logic [4:0] a1, a2, b1, b2;
      for (int i = 0; i < 300; i++) begin
         a1 = 5'($urandom_range(0, 7)); a2 = 5'($urandom_range(0, 7));
         b1 = 5'($urandom_range(0, 7)); b2 = 5'($urandom_range(0, 7));
         step(1'b0, ($urandom_range(0, 9) != 0), 1'b0,
              1'($urandom_range(0, 1)), a1, {$urandom, $urandom},
              1'($urandom_range(0, 1)), a2, {$urandom, $urandom}, b1, b2);
         e = sb.pop_front();
         checks++;
         if (busy !== e.busy || read_data1 !== e.d1 || read_data2 !== e.d2 ||
             nb_data1 !== e.n1 || nb_data2 !== e.n2) begin
            errors++;
            $display("FAIL random i=%0d got %h %h %h %h expected %h %h %h %h", i,
                     read_data1, read_data2, nb_data1, nb_data2, e.d1, e.d2, e.n1, e.n2);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_mem[i] = 64'd0;
      m_clear = 1'b1; m_ptr = 0; m_busy = 1'b1;
      m_d1 = 64'd0; m_d2 = 64'd0; m_n1 = 64'd0; m_n2 = 64'd0;
      Rst = 1'b1; En = 1'b0; clear_req = 1'b0;
      read_reg1 = 5'd0; read_reg2 = 5'd0; write_reg1 = 5'd0; write_reg2 = 5'd0;
      write_data1 = 64'd0; write_data2 = 64'd0; reg_write1 = 1'b0; reg_write2 = 1'b0;
      @(posedge Clk);
      #1;
      test_reset();
      test_basic();
      test_dual_write();
      test_bypass();
      test_enable_hold();
      test_clear();
      test_reset_mid_sweep();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
